// File: rtl/control_multiciclo.sv
// control_multiciclo
//   Multicycle control unit for an RV32I core. Steps one instruction at a time
//   through fetch/decode/execute/memory/writeback. In each state it drives the
//   datapath enables and selects from the instruction register and the ALU
//   zero flag. It also counts retired instructions and flags unsupported ones.
//
// Ports
//   clk_CU         in   clock, rising edge
//   reset_CU       in   synchronous reset, active low
//   inst_CU        in   [31:0] instruction register contents
//   zero_CU        in   ALU zero flag
//   pcWrite_CU     out  PC load enable
//   irWrite_CU     out  instruction register load enable
//   adrSrc_CU      out  memory address select (0 PC, 1 ALUOut)
//   memWrite_CU    out  data memory write enable
//   regWrite_CU    out  register file write enable
//   aluSrcA_CU     out  [1:0] ALU A (00 PC, 01 oldPC, 10 rs1)
//   aluSrcB_CU     out  [1:0] ALU B (00 rs2, 01 immExt, 10 const 4)
//   rscSrc_CU      out  [1:0] result (00 ALUOut, 01 mem data, 10 ALU result)
//   inmSrc_CU      out  [1:0] immediate format (00 I, 01 S, 10 B, 11 J)
//   aluControl_CU  out  [2:0] ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   illegal_OUT    out  high during DECODE of an unsupported instruction
//   instret_OUT    out  [31:0] retired instruction count
//   state_OUT      out  [3:0] current state
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | read instruction, load IR, PC <= PC + 4
// DECODE   | classify opcode, ALUOut <= oldPC + imm
// MEMADR   | ALUOut <= rs1 + imm for lw/sw
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= memory data
// MEMWRITE | write rs2 to data memory at ALUOut
// EXECR    | R-type operation rs1 op rs2
// ALUWB    | rd <= ALUOut
// EXECI    | I-type operation rs1 op imm
// JAL      | PC <= target, ALUOut <= oldPC + 4
// BEQ      | compare rs1/rs2, PC <= target when equal

module control_multiciclo (
  input  logic        clk_CU,
  input  logic        reset_CU,
  input  logic [31:0] inst_CU,
  input  logic        zero_CU,
  output logic        pcWrite_CU,
  output logic        irWrite_CU,
  output logic        adrSrc_CU,
  output logic        memWrite_CU,
  output logic        regWrite_CU,
  output logic [1:0]  aluSrcA_CU,
  output logic [1:0]  aluSrcB_CU,
  output logic [1:0]  rscSrc_CU,
  output logic [1:0]  inmSrc_CU,
  output logic [2:0]  aluControl_CU,
  output logic        illegal_OUT,
  output logic [31:0] instret_OUT,
  output logic [3:0]  state_OUT
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instret;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_is_lw, w_is_sw, w_is_r, w_is_i, w_is_jal, w_is_beq;
  logic        w_funct_ok;
  logic        w_illegal_inst;
  logic        w_retire;
  logic [2:0]  w_alu_dec;
  logic        w_unused_inst;

  logic        w_pc_write, w_ir_write, w_mem_write, w_reg_write;

  assign w_opcode = inst_CU[6:0];
  assign w_funct3 = inst_CU[14:12];
  assign w_unused_inst = ^{inst_CU[31], inst_CU[29:15], inst_CU[11:7]};

  assign w_is_lw  = (w_opcode == 7'b0000011);
  assign w_is_sw  = (w_opcode == 7'b0100011);
  assign w_is_r   = (w_opcode == 7'b0110011);
  assign w_is_i   = (w_opcode == 7'b0010011);
  assign w_is_jal = (w_opcode == 7'b1101111);
  assign w_is_beq = (w_opcode == 7'b1100011);

  assign w_funct_ok = (w_funct3 == 3'b000) || (w_funct3 == 3'b010) ||
                      (w_funct3 == 3'b110) || (w_funct3 == 3'b111);

  assign w_illegal_inst = !(w_is_lw || w_is_sw || w_is_jal || w_is_beq ||
                            ((w_is_r || w_is_i) && w_funct_ok));

  assign w_retire = (r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                    (r_state == S_ALUWB) || (r_state == S_BEQ);

  // inst[30] selects sub only for R-type; for addi it is an immediate bit.
  always_comb begin
    w_alu_dec = 3'b000;
    case (w_funct3)
      3'b000:  w_alu_dec = (w_is_r && inst_CU[30]) ? 3'b001 : 3'b000;
      3'b010:  w_alu_dec = 3'b101;
      3'b110:  w_alu_dec = 3'b011;
      3'b111:  w_alu_dec = 3'b010;
      default: w_alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    inmSrc_CU = 2'b00;
    if (w_is_sw)       inmSrc_CU = 2'b01;
    else if (w_is_beq) inmSrc_CU = 2'b10;
    else if (w_is_jal) inmSrc_CU = 2'b11;
  end

  always_ff @(posedge clk_CU) begin
    if (!reset_CU) begin
      r_state   <= S_FETCH;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

  always_comb begin
    w_next        = S_FETCH;
    w_pc_write    = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    adrSrc_CU     = 1'b0;
    aluSrcA_CU    = 2'b00;
    aluSrcB_CU    = 2'b00;
    rscSrc_CU     = 2'b00;
    aluControl_CU = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_next     = S_DECODE;
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        aluSrcB_CU = 2'b10;
        rscSrc_CU  = 2'b10;
      end
      S_DECODE: begin
        aluSrcA_CU = 2'b01;
        aluSrcB_CU = 2'b01;
        if (w_is_lw || w_is_sw)         w_next = S_MEMADR;
        else if (w_is_r && w_funct_ok)  w_next = S_EXECR;
        else if (w_is_i && w_funct_ok)  w_next = S_EXECI;
        else if (w_is_jal)              w_next = S_JAL;
        else if (w_is_beq)              w_next = S_BEQ;
        else                            w_next = S_FETCH;
      end
      S_MEMADR: begin
        w_next     = w_is_sw ? S_MEMWRITE : S_MEMREAD;
        aluSrcA_CU = 2'b10;
        aluSrcB_CU = 2'b01;
      end
      S_MEMREAD: begin
        w_next    = S_MEMWB;
        adrSrc_CU = 1'b1;
      end
      S_MEMWB: begin
        rscSrc_CU   = 2'b01;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc_CU   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        w_next        = S_ALUWB;
        aluSrcA_CU    = 2'b10;
        aluControl_CU = w_alu_dec;
      end
      S_EXECI: begin
        w_next        = S_ALUWB;
        aluSrcA_CU    = 2'b10;
        aluSrcB_CU    = 2'b01;
        aluControl_CU = w_alu_dec;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
      end
      S_JAL: begin
        w_next     = S_ALUWB;
        aluSrcA_CU = 2'b01;
        aluSrcB_CU = 2'b10;
        w_pc_write = 1'b1;
      end
      S_BEQ: begin
        aluSrcA_CU    = 2'b10;
        aluControl_CU = 3'b001;
        w_pc_write    = zero_CU;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Enables are gated by reset so nothing is written while reset is held.
  assign pcWrite_CU  = w_pc_write  & reset_CU;
  assign irWrite_CU  = w_ir_write  & reset_CU;
  assign memWrite_CU = w_mem_write & reset_CU;
  assign regWrite_CU = w_reg_write & reset_CU;

  assign illegal_OUT = (r_state == S_DECODE) && w_illegal_inst && reset_CU;
  assign instret_OUT = r_instret;
  assign state_OUT   = r_state;

endmodule

// File: tb/tb_control_multiciclo.sv
module tb_control_multiciclo;

  logic        clk_CU = 1'b0;
  logic        reset_CU;
  logic [31:0] inst_CU;
  logic        zero_CU;
  logic        pcWrite_CU, irWrite_CU, adrSrc_CU, memWrite_CU, regWrite_CU;
  logic [1:0]  aluSrcA_CU, aluSrcB_CU, rscSrc_CU, inmSrc_CU;
  logic [2:0]  aluControl_CU;
  logic        illegal_OUT;
  logic [31:0] instret_OUT;
  logic [3:0]  state_OUT;

  always #5 clk_CU = ~clk_CU;

  control_multiciclo dut (
    .clk_CU(clk_CU), .reset_CU(reset_CU), .inst_CU(inst_CU), .zero_CU(zero_CU),
    .pcWrite_CU(pcWrite_CU), .irWrite_CU(irWrite_CU), .adrSrc_CU(adrSrc_CU),
    .memWrite_CU(memWrite_CU), .regWrite_CU(regWrite_CU),
    .aluSrcA_CU(aluSrcA_CU), .aluSrcB_CU(aluSrcB_CU), .rscSrc_CU(rscSrc_CU),
    .inmSrc_CU(inmSrc_CU), .aluControl_CU(aluControl_CU),
    .illegal_OUT(illegal_OUT), .instret_OUT(instret_OUT), .state_OUT(state_OUT)
  );

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cnt;

  // {pc, ir, adr, memW, regW, A, B, rsc, inm, alu, illegal}
  function automatic logic [16:0] vec(input logic pc, input logic ir, input logic adr,
                                      input logic mw, input logic rw, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] rsc,
                                      input logic [1:0] inm, input logic [2:0] alu,
                                      input logic ill);
    return {pc, ir, adr, mw, rw, a, b, rsc, inm, alu, ill};
  endfunction

  function automatic logic [16:0] state_vec(input logic [3:0] s, input logic [1:0] inm,
                                            input logic [2:0] alu, input logic z,
                                            input logic ill);
    case (s)
      4'd0:    return vec(1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, inm, 3'b000, 0);
      4'd1:    return vec(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, inm, 3'b000, ill);
      4'd2:    return vec(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, inm, 3'b000, 0);
      4'd3:    return vec(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, inm, 3'b000, 0);
      4'd4:    return vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, inm, 3'b000, 0);
      4'd5:    return vec(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, inm, 3'b000, 0);
      4'd6:    return vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, inm, alu, 0);
      4'd7:    return vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, inm, 3'b000, 0);
      4'd8:    return vec(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, inm, alu, 0);
      4'd9:    return vec(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, inm, 3'b000, 0);
      4'd10:   return vec(z, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, inm, 3'b001, 0);
      default: return 17'd0;
    endcase
  endfunction

  // FETCH selects while reset is held: every enable forced low.
  function automatic logic [16:0] reset_vec(input logic [1:0] inm);
    return vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, inm, 3'b000, 0);
  endfunction

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk_CU) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [16:0] act;
      e   = q.pop_front();
      act = {pcWrite_CU, irWrite_CU, adrSrc_CU, memWrite_CU, regWrite_CU, aluSrcA_CU,
             aluSrcB_CU, rscSrc_CU, inmSrc_CU, aluControl_CU, illegal_OUT};
      checks++;
      if (state_OUT !== e.st) begin
        errors++;
        $display("FAIL %s state: got %0d expected %0d", e.name, state_OUT, e.st);
      end
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl(state %0d): got %05h expected %05h", e.name, e.st, act, e.ctl);
      end
      checks++;
      if (instret_OUT !== e.cnt) begin
        errors++;
        $display("FAIL %s instret: got %08h expected %08h", e.name, instret_OUT, e.cnt);
      end
    end
  end

  task automatic push(input logic [3:0] st, input logic [16:0] ctl, input string name);
    exp_t e;
    e.st   = st;
    e.ctl  = ctl;
    e.cnt  = cnt;
    e.name = name;
    q.push_back(e);
  endtask

  // Called at posedge+1 of the instruction's FETCH cycle; returns at posedge+1
  // of the following cycle.
  task automatic issue(input string name, input logic [31:0] inst, input logic z,
                       input logic [1:0] inm, input logic [2:0] alu, input int n,
                       input logic [4:0][3:0] sts, input logic ill, input logic wrap);
    for (int i = 0; i < n; i++) begin
      inst_CU = inst;
      zero_CU = z;
      if (wrap && i == n - 1) begin
        cnt = 32'hFFFF_FFFF;
        force dut.r_instret = 32'hFFFF_FFFF;
      end
      push(sts[4-i], state_vec(sts[4-i], inm, alu, z, ill), name);
      if (wrap && i == n - 1) begin
        #1 release dut.r_instret;
      end
      @(posedge clk_CU);
      #1;
    end
    if (!ill) cnt = cnt + 32'd1;
  endtask

  initial begin
    reset_CU = 1'b0;
    inst_CU  = 32'h0000A103;
    zero_CU  = 1'b0;
    cnt      = 32'd0;

    @(posedge clk_CU);
    #1;
    repeat (2) begin
      push(4'd0, reset_vec(2'b00), "reset");
      @(posedge clk_CU);
      #1;
    end
    reset_CU = 1'b1;

    issue("lw",    32'h0000A103, 0, 2'b00, 3'b000, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 0, 0);
    issue("sw",    32'h00202223, 0, 2'b01, 3'b000, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}, 0, 0);
    issue("add",   32'h002081B3, 1, 2'b00, 3'b000, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 0, 0);
    issue("sub",   32'h402081B3, 0, 2'b00, 3'b001, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 0, 0);
    issue("beq_t", 32'h00000463, 1, 2'b10, 3'b000, 3, {4'd0, 4'd1, 4'd10, 4'd0, 4'd0}, 0, 0);
    issue("beq_n", 32'h00000463, 0, 2'b10, 3'b000, 3, {4'd0, 4'd1, 4'd10, 4'd0, 4'd0}, 0, 0);
    issue("jal",   32'h010000EF, 0, 2'b11, 3'b000, 4, {4'd0, 4'd1, 4'd9, 4'd7, 4'd0}, 0, 0);
    issue("addi",  32'h00508093, 0, 2'b00, 3'b000, 4, {4'd0, 4'd1, 4'd8, 4'd7, 4'd0}, 0, 0);
    issue("addi30",32'h40008093, 0, 2'b00, 3'b000, 4, {4'd0, 4'd1, 4'd8, 4'd7, 4'd0}, 0, 0);
    issue("ori",   32'h0030E093, 0, 2'b00, 3'b011, 4, {4'd0, 4'd1, 4'd8, 4'd7, 4'd0}, 0, 0);
    issue("andi",  32'h4000F093, 0, 2'b00, 3'b010, 4, {4'd0, 4'd1, 4'd8, 4'd7, 4'd0}, 0, 0);
    issue("slt",   32'h0020A1B3, 0, 2'b00, 3'b101, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 0, 0);
    issue("or",    32'h0020E1B3, 0, 2'b00, 3'b011, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 0, 0);
    issue("and",   32'h0020F1B3, 0, 2'b00, 3'b010, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 0, 0);
    issue("ill_op",32'h0000007F, 0, 2'b00, 3'b000, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0}, 1, 0);
    issue("ill_f3",32'h002091B3, 0, 2'b00, 3'b000, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0}, 1, 0);

    // lw abandoned by a reset asserted in MEMREAD.
    inst_CU = 32'h0000A103;
    for (int i = 0; i < 3; i++) begin
      push(i[3:0], state_vec(i[3:0], 2'b00, 3'b000, 0, 0), "lw_rst");
      @(posedge clk_CU);
      #1;
    end
    reset_CU = 1'b0;
    push(4'd3, state_vec(4'd3, 2'b00, 3'b000, 0, 0), "lw_rst");
    @(posedge clk_CU);
    #1;
    cnt = 32'd0;
    push(4'd0, reset_vec(2'b00), "lw_rst");
    @(posedge clk_CU);
    #1;
    reset_CU = 1'b1;

    issue("wrap",  32'h002081B3, 0, 2'b00, 3'b000, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 0, 1);
    issue("beq_w", 32'h00000463, 0, 2'b10, 3'b000, 3, {4'd0, 4'd1, 4'd10, 4'd0, 4'd0}, 0, 0);
    inst_CU = 32'h002081B3;
    push(4'd0, state_vec(4'd0, 2'b00, 3'b000, 0, 0), "tail");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_CU);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected records left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multicycle control unit for the RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback states. Each cycle it drives the enable and select lines of the multicycle datapath from the instruction-register contents and the ALU zero flag. It also keeps a retired-instruction counter and flags unsupported opcodes.

## Interface
- No parameters.
- clk_CU  in  1  clock; all state updates on the rising edge.
- reset_CU  in  1  synchronous, active-low reset.
- inst_CU  in  32  instruction register contents.
- zero_CU  in  1  ALU zero flag for the current cycle.
- pcWrite_CU  out  1  PC load enable.
- irWrite_CU  out  1  instruction register load enable.
- adrSrc_CU  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memWrite_CU  out  1  data memory write enable.
- regWrite_CU  out  1  register file write enable.
- aluSrcA_CU  out  2  ALU operand A: 00 = PC, 01 = oldPC, 10 = rs1.
- aluSrcB_CU  out  2  ALU operand B: 00 = rs2, 01 = immExt, 10 = constant 4.
- rscSrc_CU  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- inmSrc_CU  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- aluControl_CU  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal_OUT  out  1  one-cycle pulse on an unsupported instruction.
- instret_OUT  out  32  count of retired instructions.
- state_OUT  out  4  current state, for debug.

## Operation
- Supported instructions: lw, sw, R-type (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), beq, jal.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10.
- Per-state outputs. Any output not listed is 0, and selects not listed are don't-care but driven 00.
  - FETCH: adrSrc=0, irWrite=1, A=00, B=10, add, rscSrc=10, pcWrite=1.
  - DECODE: A=01, B=01, add. This computes the branch/jump target.
  - MEMADR: A=10, B=01, add.
  - MEMREAD: adrSrc=1, rscSrc=00.
  - MEMWB: rscSrc=01, regWrite=1.
  - MEMWRITE: adrSrc=1, memWrite=1.
  - EXECR: A=10, B=00, ALU decoded from funct fields.
  - EXECI: A=10, B=01, ALU decoded from funct fields.
  - ALUWB: rscSrc=00, regWrite=1.
  - JAL: A=01, B=10, add, rscSrc=00, pcWrite=1.
  - BEQ: A=10, B=00, sub, rscSrc=00, pcWrite=zero_CU.
- State transitions:
  - FETCH→DECODE.
  - DECODE by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 (R-type) → EXECR.
    - 0010011 (I-type ALU) → EXECI.
    - 1101111 (jal) → JAL.
    - 1100011 (beq) → BEQ.
    - Any other opcode → FETCH.
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD→MEMWB.
  - EXECR, EXECI and JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
- Funct decode, by funct3:
  - 000 → sub only when the opcode is R-type and inst[30]=1; otherwise add.
  - 010 → slt.
  - 110 → or.
  - 111 → and.
  - Any other funct3 on an R/I opcode: DECODE goes to FETCH and the instruction is treated as illegal.
- inmSrc_CU is decoded combinationally from the opcode in every state: I for lw and I-type ALU, S for sw, B for beq, J for jal, 00 otherwise.
- Illegal instruction: illegal_OUT is 1 for the DECODE cycle. There are no register or memory writes, and instret_OUT is not incremented.
- instret_OUT increments by 1 on the clock edge leaving MEMWB, MEMWRITE, ALUWB or BEQ. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset: on a rising edge with reset_CU=0, state goes to FETCH, instret_OUT to 0 and illegal_OUT to 0.
- While reset_CU=0, pcWrite, irWrite, regWrite and memWrite are forced to 0 combinationally.
- Reset in the middle of an instruction abandons it. No write enable is asserted after the reset edge until the next FETCH.
- Instruction latency in cycles, including FETCH: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3 (taken or not), illegal 2.
- Outputs are Moore functions of state and inst_CU. The one exception is pcWrite in BEQ, which also depends on zero_CU in the same cycle.
- inst_CU must be stable from DECODE until the instruction's last state. The IR loads at the end of FETCH.

## Test plan
- Reset: hold reset_CU=0 for 2 cycles with inst_CU=0x0000A103.
  - Required: state_OUT=0 and all enables 0 during reset.
  - Required: after release, FETCH with irWrite=1 and pcWrite=1; instret_OUT=0.
- lw x2,0(x1) (0x0000A103):
  - Required state sequence 0,1,2,3,4.
  - Required: adrSrc=1 in state 3; regWrite=1 and rscSrc=01 in state 4.
  - Required: instret_OUT goes 0→1 after state 4.
- sw x2,4(x0) (0x00202223), then add x3,x1,x2 (0x002081B3):
  - sw required: states 0,1,2,5, with memWrite=1 only in state 5 and inmSrc=01.
  - add required: states 0,1,6,7, with aluControl=000.
  - Repeat with 0x402081B3: required aluControl=001.
- beq x0,x0,8 (0x00000463):
  - With zero_CU=1 in BEQ: required pcWrite=1 and inmSrc=10.
  - With zero_CU=0: required pcWrite=0.
  - Both cases required: 3 cycles and instret incremented.
- jal x1,16 (0x010000EF):
  - Required states 0,1,9,7.
  - Required: pcWrite=1 in states 0 and 9; regWrite=1 in state 7; inmSrc=11.
- Illegal and wrap cases:
  - inst_CU=0x0000007F: required illegal_OUT=1 in DECODE, then FETCH, with no writes and instret unchanged.
  - Reset asserted during MEMREAD: required that no MEMWB write occurs.
  - Force instret_OUT to 0xFFFFFFFF, then retire one instruction: required instret_OUT=0.
